// File: rtl/pwm_period_ctrl_pkg.sv
// Shared types and constants for the 4-bit PWM period controller.
// State codes are plain constants so the encoding stays stable for older tooling.
package pwm_period_ctrl_pkg;

  localparam int PWM_W = 4;

  typedef logic [PWM_W-1:0] pwm_val_t;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_DRAIN = 2'b10;

  // One duty/period setting. Both the pending and the shadow copy use this shape.
  typedef struct packed {
    pwm_val_t duty;
    pwm_val_t period;
  } pwm_cfg_t;

endpackage

// File: rtl/pwm_period_ctrl_compare_4.sv
// 4-bit unsigned magnitude comparator shared by the duty test and the wrap test.
module compare_4
  import pwm_period_ctrl_pkg::*;
(
  input  pwm_val_t a,
  input  pwm_val_t b,
  output logic     a_less_b,
  output logic     a_equal_b
);

  assign a_less_b  = (a < b);
  assign a_equal_b = (a == b);

endmodule

// File: rtl/pwm_period_ctrl.sv
// One PWM channel: period counter, pending/shadow duty and period registers,
// commit-at-boundary load handshake and an IDLE/RUN/DRAIN start-stop FSM.
module pwm_period_ctrl
  import pwm_period_ctrl_pkg::*;
#(
  parameter pwm_val_t RESET_PERIOD = 4'd15,
  parameter pwm_val_t RESET_DUTY   = 4'd0
) (
  input  logic     clk,
  input  logic     reset_n,
  input  logic     enable,
  input  logic     load,
  input  pwm_val_t duty_in,
  input  pwm_val_t period_in,
  output logic     load_ack,
  output logic     pwm_out,
  output logic     period_tick,
  output logic     busy
);

  logic [1:0] state_q, state_d;
  pwm_val_t   count_q, count_d;
  logic       pend_valid_q, pend_valid_d;
  pwm_cfg_t   pend_q, pend_d;
  pwm_cfg_t   shadow_q, shadow_d;
  logic       pwm_out_q, pwm_out_d;
  logic       load_ack_q, load_ack_d;
  logic       period_tick_q, period_tick_d;

  logic running;
  logic count_at_period;
  logic count_below_duty;
  logic wrap;
  logic commit;

  compare_4 u_duty_cmp (
    .a         (count_q),
    .b         (shadow_q.duty),
    .a_less_b  (count_below_duty),
    .a_equal_b ()
  );

  compare_4 u_wrap_cmp (
    .a         (count_q),
    .b         (shadow_q.period),
    .a_less_b  (),
    .a_equal_b (count_at_period)
  );

  assign running = (state_q != ST_IDLE);
  assign wrap    = running & count_at_period;
  // New settings only land while idle or on the last cycle of a period, so
  // the next period always starts at count 0 with a consistent duty/period pair.
  assign commit  = pend_valid_q & (~running | wrap);

  // NOTE: every signal gets its default before the case/if tree, otherwise
  // a missed branch would infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (enable) state_d = ST_RUN;
      ST_RUN:   if (!enable) state_d = wrap ? ST_IDLE : ST_DRAIN;
      ST_DRAIN: begin
        if (enable)    state_d = ST_RUN;
        else if (wrap) state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    count_d = '0;
    if (running && !wrap) count_d = count_q + 4'd1;
  end

  // A load landing in the same cycle as a commit becomes the next pending value.
  always_comb begin
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    shadow_d     = shadow_q;
    if (commit) begin
      shadow_d     = pend_q;
      pend_valid_d = 1'b0;
    end
    if (load) begin
      pend_d       = '{duty: duty_in, period: period_in};
      pend_valid_d = 1'b1;
    end
  end

  always_comb begin
    pwm_out_d     = running & count_below_duty;
    period_tick_d = wrap;
    load_ack_d    = commit;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      count_q       <= '0;
      pend_valid_q  <= 1'b0;
      pend_q        <= '0;
      shadow_q      <= '{duty: RESET_DUTY, period: RESET_PERIOD};
      pwm_out_q     <= 1'b0;
      load_ack_q    <= 1'b0;
      period_tick_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      pend_valid_q  <= pend_valid_d;
      pend_q        <= pend_d;
      shadow_q      <= shadow_d;
      pwm_out_q     <= pwm_out_d;
      load_ack_q    <= load_ack_d;
      period_tick_q <= period_tick_d;
    end
  end

  assign pwm_out     = pwm_out_q;
  assign load_ack    = load_ack_q;
  assign period_tick = period_tick_q;
  assign busy        = running;

endmodule

// File: tb/tb_pwm_period_ctrl.sv
// Self-checking bench for pwm_period_ctrl: directed scenarios plus random
// stimulus, all compared cycle by cycle against a behavioural channel model.
module tb_pwm_period_ctrl;

  logic       clk;
  logic       reset_n;
  logic       enable;
  logic       load;
  logic [3:0] duty_in;
  logic [3:0] period_in;
  logic       load_ack;
  logic       pwm_out;
  logic       period_tick;
  logic       busy;

  int total = 0;
  int bad   = 0;

  // Behavioural model: "running" flag plus a modulo-(period+1) counter.
  bit m_run, m_pv;
  int m_cnt, m_duty, m_per, m_pd, m_pp;
  bit e_pwm, e_tick, e_ack;

  pwm_period_ctrl dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .load        (load),
    .duty_in     (duty_in),
    .period_in   (period_in),
    .load_ack    (load_ack),
    .pwm_out     (pwm_out),
    .period_tick (period_tick),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_cnt = 0; m_duty = 0; m_per = 15;
    m_pv = 0; m_pd = 0; m_pp = 0;
    e_pwm = 0; e_tick = 0; e_ack = 0;
  endtask

  task automatic model_step(input bit en, input bit ld, input int d, input int p);
    bit at_end, take;
    at_end = m_run && (m_cnt == m_per);
    take   = m_pv && (!m_run || at_end);
    e_pwm  = m_run && (m_cnt < m_duty);
    e_tick = at_end;
    e_ack  = take;
    m_cnt  = m_run ? (m_cnt + 1) % (m_per + 1) : 0;
    m_run  = (m_run && !at_end) || en;
    if (take) begin
      m_duty = m_pd;
      m_per  = m_pp;
    end
    if (ld) begin
      m_pd = d; m_pp = p; m_pv = 1;
    end else if (take) begin
      m_pv = 0;
    end
  endtask

  // One clock: drive inputs, step the model at the edge, compare 1 time unit later.
  task automatic cyc(input bit en, input bit ld, input int d, input int p);
    enable    = en;
    load      = ld;
    duty_in   = 4'(d);
    period_in = 4'(p);
    @(posedge clk);
    model_step(en, ld, d, p);
    #1;
    check("pwm_out", pwm_out, e_pwm);
    check("period_tick", period_tick, e_tick);
    check("load_ack", load_ack, e_ack);
    check("busy", busy, m_run);
  endtask

  task automatic run_until_cnt(input int target);
    int n = 0;
    while (m_cnt != target && n < 40) begin
      cyc(1, 0, 0, 0);
      n++;
    end
    check("reach_cnt_bound", n < 40, 1);
  endtask

  task automatic count_pwm(input string tag, input int len, input int exp_hi);
    int hi = 0;
    repeat (len) begin
      cyc(1, 0, 0, 0);
      hi += pwm_out;
    end
    check(tag, hi, exp_hi);
  endtask

  task automatic stop_and_idle();
    int n = 0;
    while (busy && n < 40) begin
      cyc(0, 0, 0, 0);
      n++;
    end
    check("idle_bound", n < 40, 1);
  endtask

  initial begin
    int lat, acks, ticks, n, t_first, t_second;
    bit en_r;

    reset_n = 1'b0; enable = 0; load = 0; duty_in = 0; period_in = 0;
    model_reset();
    #12;
    check("rst_pwm_out", pwm_out, 0);
    check("rst_period_tick", period_tick, 0);
    check("rst_load_ack", load_ack, 0);
    check("rst_busy", busy, 0);
    @(negedge clk) reset_n = 1'b1;

    // Reset settings: 16-cycle period, output never high.
    t_first = -1; t_second = -1; ticks = 0;
    for (int i = 0; i < 40; i++) begin
      cyc(1, 0, 0, 0);
      ticks += pwm_out;
      if (period_tick) begin
        if (t_first < 0) t_first = i;
        else if (t_second < 0) t_second = i;
      end
    end
    check("reset_tick_interval", t_second - t_first, 16);
    check("reset_pwm_high_count", ticks, 0);
    stop_and_idle();

    // Load while idle: acknowledged two edges after the load strobe.
    cyc(0, 1, 3, 7);
    lat = 1;
    while (!load_ack && lat < 6) begin
      cyc(0, 0, 0, 0);
      lat++;
    end
    check("idle_ack_latency", lat, 2);
    repeat (12) cyc(1, 0, 0, 0);
    count_pwm("duty3_per7_high", 8, 3);

    // Mid-period load at count 2: old waveform finishes, then 6 of 10.
    run_until_cnt(2);
    cyc(1, 1, 6, 9);
    repeat (25) cyc(1, 0, 0, 0);
    count_pwm("duty6_per9_high", 10, 6);

    // Back-to-back loads: only the last one is committed and acknowledged.
    run_until_cnt(3);
    cyc(1, 1, 1, 9);
    cyc(1, 1, 5, 9);
    acks = 0;
    repeat (24) begin
      cyc(1, 0, 0, 0);
      acks += load_ack;
    end
    check("single_ack_for_two_loads", acks, 1);
    count_pwm("duty5_per9_high", 10, 5);

    // Boundary settings.
    cyc(1, 1, 0, 7);
    repeat (20) cyc(1, 0, 0, 0);
    count_pwm("duty0_high", 8, 0);
    cyc(1, 1, 15, 4);
    repeat (20) cyc(1, 0, 0, 0);
    count_pwm("duty15_per4_high", 5, 5);
    cyc(1, 1, 0, 0);
    repeat (20) cyc(1, 0, 0, 0);
    ticks = 0;
    repeat (6) begin
      cyc(1, 0, 0, 0);
      ticks += period_tick;
    end
    check("per0_tick_every_cycle", ticks, 6);

    // Disable at count 4 of an 8-cycle period: runs to 7, wraps, then idles.
    cyc(1, 1, 3, 7);
    repeat (20) cyc(1, 0, 0, 0);
    run_until_cnt(4);
    n = 0;
    while (busy && n < 20) begin
      cyc(0, 0, 0, 0);
      n++;
    end
    check("drain_cycles_to_idle", n, 4);

    // Randomized traffic with phases of mostly-on / mostly-off enable.
    en_r = 1;
    for (int i = 0; i < 900; i++) begin
      if ($urandom_range(0, 29) == 0) en_r = !en_r;
      cyc(en_r ? ($urandom_range(0, 19) != 0) : ($urandom_range(0, 19) == 0),
          $urandom_range(0, 5) == 0,
          int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
    end

    // Reset in the middle of a period clears every output immediately.
    cyc(1, 1, 9, 12);
    repeat (7) cyc(1, 0, 0, 0);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_pwm_out", pwm_out, 0);
    check("midrst_period_tick", period_tick, 0);
    check("midrst_load_ack", load_ack, 0);
    check("midrst_busy", busy, 0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    repeat (40) cyc(1, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
